// File: rtl/bird_pkg.sv
// Shared definitions for the bird game blocks.
// Holds the bird FSM state type and the default geometry/physics constants
// so the motion, pipe and collision blocks agree on one set of numbers.
package bird_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FLY,
    DEAD
  } bird_state_t;

  localparam int DEF_COORD_W  = 11;
  localparam int DEF_VEL_W    = 6;
  localparam int DEF_START_Y  = 200;
  localparam int DEF_X_POS    = 150;
  localparam int DEF_Y_MIN    = 0;
  localparam int DEF_Y_MAX    = 460;
  localparam int DEF_GRAVITY  = 1;
  localparam int DEF_GRAV_DIV = 4;
  localparam int DEF_FLAP_VEL = -6;
  localparam int DEF_MAX_FALL = 7;

endpackage

// File: rtl/edge_pulse.sv
// Rising-edge detector.
//   clk   : clock, rising edge
//   reset : synchronous, active-high; clears the input history
//   din   : level input
//   pulse : high for the cycle in which din is high and was low last cycle
module edge_pulse (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic din_q;

  always_ff @(posedge clk) begin
    if (reset) din_q <= 1'b0;
    else       din_q <= din;
  end

  assign pulse = din & ~din_q;

endmodule

// File: rtl/bird_motion.sv
// Vertical motion of the bird: gravity, flap impulse, ceiling/floor contact.
//   clk, reset  : clock and synchronous active-high reset
//   enable      : high = game running, low = return to IDLE
//   tick        : one-cycle frame strobe; motion only advances on it
//   flap        : button level; a rising edge requests a flap
//   bird_x      : constant X_POS
//   bird_y      : registered vertical position
//   velocity    : registered signed velocity (positive = downward)
//   dead        : high while in DEAD
//   hit_floor   : one-cycle pulse after the tick that reached the floor
//   hit_ceiling : one-cycle pulse after the tick that reached the ceiling
module bird_motion
  import bird_pkg::*;
#(
  parameter int COORD_W  = DEF_COORD_W,
  parameter int VEL_W    = DEF_VEL_W,
  parameter int START_Y  = DEF_START_Y,
  parameter int X_POS    = DEF_X_POS,
  parameter int Y_MIN    = DEF_Y_MIN,
  parameter int Y_MAX    = DEF_Y_MAX,
  parameter int GRAVITY  = DEF_GRAVITY,
  parameter int GRAV_DIV = DEF_GRAV_DIV,
  parameter int FLAP_VEL = DEF_FLAP_VEL,
  parameter int MAX_FALL = DEF_MAX_FALL
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               tick,
  input  logic               flap,
  output logic [COORD_W-1:0] bird_x,
  output logic [COORD_W-1:0] bird_y,
  output logic [VEL_W-1:0]   velocity,
  output logic               dead,
  output logic               hit_floor,
  output logic               hit_ceiling
);

  localparam int CNT_W = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;
  localparam int YW    = COORD_W + 2;
  localparam int VW1   = VEL_W + 1;

  localparam logic [CNT_W-1:0]        CNT_LAST  = CNT_W'(GRAV_DIV - 1);
  localparam logic signed [VEL_W-1:0] FLAP_V    = VEL_W'(FLAP_VEL);
  localparam logic signed [VW1-1:0]   MAX_V     = VW1'(MAX_FALL);
  localparam logic signed [VW1-1:0]   GRAV_V    = VW1'(GRAVITY);
  localparam logic signed [YW-1:0]    Y_MIN_S   = YW'(Y_MIN);
  localparam logic signed [YW-1:0]    Y_MAX_S   = YW'(Y_MAX);
  localparam logic [COORD_W-1:0]      START_Y_C = COORD_W'(START_Y);
  localparam logic [COORD_W-1:0]      X_POS_C   = COORD_W'(X_POS);
  localparam logic [COORD_W-1:0]      Y_MIN_C   = COORD_W'(Y_MIN);
  localparam logic [COORD_W-1:0]      Y_MAX_C   = COORD_W'(Y_MAX);

  bird_state_t state, state_next;

  logic [COORD_W-1:0]        y_q, y_d;
  logic signed [VEL_W-1:0]   vel_q, vel_d, vel_new;
  logic signed [VW1-1:0]     vel_sum;
  logic signed [YW-1:0]      y_next;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      pend_q, pend_d;
  logic                      hf_d, hc_d;
  logic                      flap_edge;

  edge_pulse u_flap_edge (
    .clk   (clk),
    .reset (reset),
    .din   (flap),
    .pulse (flap_edge)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = FLY;
        FLY:     if (hf_d) state_next = DEAD;
        DEAD:    state_next = DEAD;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    dead   = (state == DEAD);
    bird_x = X_POS_C;
  end

  // A flap edge arriving on the tick cycle itself is folded in directly,
  // so it needs no detour through the pending flag.
  always_comb begin
    y_d     = y_q;
    vel_d   = vel_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hf_d    = 1'b0;
    hc_d    = 1'b0;
    vel_new = vel_q;
    vel_sum = '0;
    y_next  = '0;
    if (!enable || state == IDLE) begin
      y_d    = START_Y_C;
      vel_d  = '0;
      cnt_d  = '0;
      pend_d = 1'b0;
    end else if (state == FLY) begin
      if (tick) begin
        if (pend_q || flap_edge) begin
          vel_new = FLAP_V;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          vel_sum = VW1'(vel_q) + GRAV_V;
          vel_new = (vel_sum > MAX_V) ? VEL_W'(MAX_V) : vel_sum[VEL_W-1:0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        pend_d = 1'b0;
        // Two extra bits keep the sum free of wrap-around above and below.
        y_next = $signed({2'b00, y_q}) + YW'(vel_new);
        if (y_next <= Y_MIN_S) begin
          y_d   = Y_MIN_C;
          vel_d = '0;
          hc_d  = 1'b1;
        end else if (y_next >= Y_MAX_S) begin
          y_d   = Y_MAX_C;
          vel_d = '0;
          hf_d  = 1'b1;
        end else begin
          y_d   = y_next[COORD_W-1:0];
          vel_d = vel_new;
        end
      end else if (flap_edge) begin
        pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y_q         <= START_Y_C;
      vel_q       <= '0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      hit_floor   <= 1'b0;
      hit_ceiling <= 1'b0;
    end else begin
      y_q         <= y_d;
      vel_q       <= vel_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      hit_floor   <= hf_d;
      hit_ceiling <= hc_d;
    end
  end

  assign bird_y   = y_q;
  assign velocity = vel_q;

endmodule

// File: tb/tb_bird_motion.sv
// Directed bench for bird_motion at default parameters. Expected outputs are
// pushed to a scoreboard queue with each step and compared one cycle later.
module tb_bird_motion;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        tick = 1'b0;
  logic        flap = 1'b0;
  logic [10:0] bird_x, bird_y;
  logic [5:0]  velocity;
  logic        dead, hit_floor, hit_ceiling;

  typedef struct {
    string       tag;
    logic [10:0] y;
    logic [5:0]  v;
    logic        d;
    logic        hf;
    logic        hc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  bird_motion #(
    .COORD_W (11),
    .VEL_W   (6),
    .START_Y (200),
    .X_POS   (150),
    .Y_MIN   (0),
    .Y_MAX   (460),
    .GRAVITY (1),
    .GRAV_DIV(4),
    .FLAP_VEL(-6),
    .MAX_FALL(7)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .tick       (tick),
    .flap       (flap),
    .bird_x     (bird_x),
    .bird_y     (bird_y),
    .velocity   (velocity),
    .dead       (dead),
    .hit_floor  (hit_floor),
    .hit_ceiling(hit_ceiling)
  );

  task automatic cmp(input string tag, input string what,
                     input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s.%s got=%0d exp=%0d", tag, what, got, exp);
    end
  endtask

  // Drive one cycle, then drain the scoreboard against the registered outputs.
  task automatic cyc(input logic r, input logic en, input logic tk, input logic fl);
    exp_t e;
    @(negedge clk);
    reset  = r;
    enable = en;
    tick   = tk;
    flap   = fl;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cmp(e.tag, "bird_y",      16'(bird_y),      16'(e.y));
      cmp(e.tag, "velocity",    16'(velocity),    16'(e.v));
      cmp(e.tag, "dead",        16'(dead),        16'(e.d));
      cmp(e.tag, "hit_floor",   16'(hit_floor),   16'(e.hf));
      cmp(e.tag, "hit_ceiling", 16'(hit_ceiling), 16'(e.hc));
    end
  endtask

  task automatic step(input logic r, input logic en, input logic tk, input logic fl,
                      input string tag, input int y, input int v,
                      input logic d, input logic hf, input logic hc);
    exp_t e;
    e.tag = tag;
    e.y   = 11'(y);
    e.v   = 6'(v);
    e.d   = d;
    e.hf  = hf;
    e.hc  = hc;
    sb.push_back(e);
    cyc(r, en, tk, fl);
  endtask

  initial begin
    int ys[8];
    int vs[8];
    int ey, ev, ec;
    logic fell;
    ys = '{202, 203, 204, 206, 208, 210, 212, 215};
    vs = '{1, 1, 1, 2, 2, 2, 2, 3};

    // Reset state
    step(1, 0, 0, 0, "reset", 200, 0, 0, 0, 0);
    cmp("reset", "bird_x", 16'(bird_x), 16'd150);

    // IDLE -> FLY, then gravity every fourth tick
    step(0, 1, 0, 0, "start", 200, 0, 0, 0, 0);
    step(0, 1, 1, 0, "grav1", 200, 0, 0, 0, 0);
    step(0, 1, 1, 0, "grav2", 200, 0, 0, 0, 0);
    step(0, 1, 1, 0, "grav3", 200, 0, 0, 0, 0);
    step(0, 1, 1, 0, "grav4", 201, 1, 0, 0, 0);
    step(0, 1, 0, 0, "hold",  201, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 1, 0, "climb_v3", ys[i], vs[i], 0, 0, 0);

    // Flap edge before tick, applied on the next tick
    step(0, 1, 0, 1, "flap_pend",  215, 3, 0, 0, 0);
    step(0, 1, 1, 1, "flap_apply", 209, -6, 0, 0, 0);
    step(0, 1, 1, 0, "post_flap1", 203, -6, 0, 0, 0);
    step(0, 1, 1, 0, "post_flap2", 197, -6, 0, 0, 0);
    step(0, 1, 1, 0, "post_flap3", 191, -6, 0, 0, 0);
    step(0, 1, 1, 0, "post_flap4", 186, -5, 0, 0, 0);

    // Flap edge coincident with tick; counter must restart
    step(0, 1, 1, 0, "pre_coin",  181, -5, 0, 0, 0);
    step(0, 1, 1, 1, "coin_flap", 175, -6, 0, 0, 0);
    step(0, 1, 0, 0, "idle_nt",   175, -6, 0, 0, 0);

    // Two edges before one tick collapse into one flap
    step(0, 1, 0, 1, "dbl_e1",   175, -6, 0, 0, 0);
    step(0, 1, 0, 0, "dbl_lo",   175, -6, 0, 0, 0);
    step(0, 1, 0, 1, "dbl_e2",   175, -6, 0, 0, 0);
    step(0, 1, 1, 0, "dbl_tick", 169, -6, 0, 0, 0);
    step(0, 1, 1, 0, "dbl_t1",   163, -6, 0, 0, 0);
    step(0, 1, 1, 0, "dbl_t2",   157, -6, 0, 0, 0);
    step(0, 1, 1, 0, "dbl_t3",   151, -6, 0, 0, 0);
    step(0, 1, 1, 0, "dbl_t4",   146, -5, 0, 0, 0);

    // Climb to y=5 with velocity -6, then hit the ceiling
    step(0, 1, 1, 0, "align1", 141, -5, 0, 0, 0);
    step(0, 1, 1, 0, "align2", 136, -5, 0, 0, 0);
    step(0, 1, 1, 0, "align3", 131, -5, 0, 0, 0);
    for (int k = 1; k <= 21; k++) begin
      step(0, 1, 1, 1, "rise",    131 - 6 * k, -6, 0, 0, 0);
      step(0, 1, 0, 0, "rise_nt", 131 - 6 * k, -6, 0, 0, 0);
    end
    step(0, 1, 1, 0, "ceiling",      0, 0, 0, 0, 1);
    step(0, 1, 0, 0, "ceiling_after", 0, 0, 0, 0, 0);

    // Enable dropped mid-flight
    step(0, 0, 1, 0, "en_low_fly", 200, 0, 0, 0, 0);
    step(0, 1, 0, 0, "restart",    200, 0, 0, 0, 0);

    // Free fall to the floor
    ey = 200; ev = 0; ec = 0; fell = 1'b0;
    for (int i = 0; i < 300 && !fell; i++) begin
      if (ec == 3) begin
        ec = 0;
        ev = (ev + 1 > 7) ? 7 : ev + 1;
      end else begin
        ec++;
      end
      if (ey + ev >= 460) begin
        ey = 460; ev = 0; fell = 1'b1;
      end else begin
        ey = ey + ev;
      end
      step(0, 1, 1, 0, "fall", ey, ev, fell, fell, 0);
    end

    // DEAD ignores tick and flap
    step(0, 1, 1, 1, "dead1", 460, 0, 1, 0, 0);
    step(0, 1, 0, 0, "dead2", 460, 0, 1, 0, 0);
    step(0, 1, 1, 0, "dead3", 460, 0, 1, 0, 0);
    step(0, 1, 1, 1, "dead4", 460, 0, 1, 0, 0);

    // Enable dropped in DEAD
    step(0, 0, 0, 0, "en_low_dead", 200, 0, 0, 0, 0);
    step(0, 1, 0, 0, "refly",       200, 0, 0, 0, 0);
    step(0, 1, 1, 0, "refly_t",     200, 0, 0, 0, 0);

    // Reset dominates everything and clears the gravity counter
    step(1, 1, 1, 1, "rst_dom",  200, 0, 0, 0, 0);
    step(0, 1, 0, 0, "rst_fly",  200, 0, 0, 0, 0);
    step(0, 1, 1, 0, "rst_g1",   200, 0, 0, 0, 0);
    step(0, 1, 1, 0, "rst_g2",   200, 0, 0, 0, 0);
    step(0, 1, 1, 0, "rst_g3",   200, 0, 0, 0, 0);
    step(0, 1, 1, 0, "rst_g4",   201, 1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
